// File: rtl/seq_divider_if.sv
// Start/result bus between the execute stage and the iterative divider.
// Handshake: a request is taken on a rising edge where start=1 and busy=0
// (busy acts as not-ready); results are valid and held while done=1.
interface seq_divider_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Each trial subtract is a carry-lookahead add of the inverted divisor with carry-in 1.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus,
  output logic [1:0]    state_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH:0]   pr_q;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;

  logic [WIDTH:0]   s_w;
  logic [WIDTH:0]   b_w;
  logic [WIDTH:0]   g_w;
  logic [WIDTH:0]   p_w;
  logic [WIDTH+1:0] c_w;
  logic [WIDTH:0]   t_w;
  logic             nb_w;
  logic             cla_carry;
  logic             cla_prop;
  logic [WIDTH:0]   pr_d;
  logic [WIDTH-1:0] q_d;

  // Every carry is a flat sum of group generates, so no carry waits on the previous one.
  always_comb begin
    s_w       = {pr_q[WIDTH-1:0], q_q[WIDTH-1]};
    b_w       = ~{1'b0, d_q};
    g_w       = s_w & b_w;
    p_w       = s_w ^ b_w;
    c_w       = '0;
    c_w[0]    = 1'b1;
    cla_carry = 1'b0;
    cla_prop  = 1'b0;
    for (int i = 0; i <= WIDTH; i++) begin
      cla_carry = 1'b1;
      for (int j = 0; j <= i; j++) cla_carry = cla_carry & p_w[j];
      for (int j = 0; j <= i; j++) begin
        cla_prop = g_w[j];
        for (int k = j + 1; k <= i; k++) cla_prop = cla_prop & p_w[k];
        cla_carry = cla_carry | cla_prop;
      end
      c_w[i+1] = cla_carry;
    end
    t_w  = p_w ^ c_w[WIDTH:0];
    nb_w = c_w[WIDTH+1];
    pr_d = nb_w ? t_w : s_w;
    q_d  = {q_q[WIDTH-2:0], nb_w};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      pr_q    <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              quo_q   <= '1;
              rem_q   <= bus.dividend;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= S_RUN;
              q_q     <= bus.dividend;
              pr_q    <= '0;
              d_q     <= bus.divisor;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              dbz_q   <= 1'b0;
            end
          end
        end
        S_RUN: begin
          q_q   <= q_d;
          pr_q  <= pr_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quo_q   <= q_d;
            rem_q   <= pr_d[WIDTH-1:0];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A restored partial remainder is always below the divisor, so its top bit stays clear.
  pr_top_clear: assert property (@(posedge clk) disable iff (rst) !pr_q[WIDTH]);

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign state_o         = state_q;

endmodule
